display_mode_arbiter: RTL and testbench
=======================================

# display_mode_arbiter

Sequencing controller that owns the shared LCD character path and the four push-switch pulses on behalf of the watch, watch-set, alarm-set and stopwatch mode blocks. It selects the owning mode from the DIP switches and changes owner only on LCD frame boundaries, so a frame is never mixed. It returns to watch mode after inactivity in set modes and preempts all modes when the alarm fires. It sits between the mode blocks and `lcd_driver`, replacing the top-level combinational `dip_sw` decode.

## Interface
- `TIMEOUT_S`, 30: seconds of switch inactivity in mode 1 or 2 before forced return to mode 0.
- `RING_S`, 60: maximum ring duration in seconds.
- `LAST_IDX`, 31: `index_char` value of the final character in a frame.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en_1hz` in 1: one-cycle pulse once per second.
- `dip_sw` in 4: mode request.
- `sw_pulse` in 4: debounced one-cycle switch pulses.
- `alarm_hit` in 1: one-cycle pulse from the alarm comparator.
- `index_char` in 5: character index currently being written by `lcd_driver`.
- `char_done` in 1: one-cycle pulse when `lcd_driver` finishes a character.
- `data_mode0`..`data_mode3` in 8 each: character from each mode block.
- `data_char` out 8: character to `lcd_driver`.
- `sw_mode0`..`sw_mode3` out 4 each: switch pulses routed to each mode block.
- `mode` out 2: current display owner.
- `ringing` out 1: alarm ring active.

## Operation
- Requested mode decode from `dip_sw`:
  - 4'b0001 → 1
  - 4'b0010 → 2
  - 4'b0100 → 3
  - all other values → 0
- Frame boundary: `char_done` && `index_char == LAST_IDX`.
- States:
  - RUN: `mode` == target.
    - target ≠ `mode` → PEND.
    - `alarm_hit` → RING.
  - PEND: all switch pulses dropped.
    - At a frame boundary → `mode` ← target, go to RUN.
    - If target returns to `mode` before the boundary → RUN with no owner change.
    - `alarm_hit` → RING.
  - RING: `ringing` = 1; target forced to 0, so the owner changes to 0 at the next frame boundary.
    - All `sw_pulse` are consumed, not routed; any nonzero `sw_pulse` → ring stops.
    - Ring counter reaching `RING_S` → ring stops.
    - On stop: `ringing` = 0, go to PEND/RUN toward the DIP-requested mode.
- Target = forced 0 if RING or timeout override is set, else the DIP-decoded mode.
- Timeout:
  - In RUN with `mode` ∈ {1,2}: an inactivity counter increments on `en_1hz` and clears on any nonzero `sw_pulse`.
  - Reaching `TIMEOUT_S` sets the override latch (target = 0).
  - The latch clears when `dip_sw` differs from its value at the time the latch was set.
  - The counter clears on any owner change.
- Routing: in RUN, `sw_modeN` ← `sw_pulse` for N == `mode`; all other `sw_modeN` are 0.
- Display: `data_char` = `data_modeN` with N = `mode` (combinational mux on the registered `mode`).
- Counters:
  - Inactivity counter is `$clog2(TIMEOUT_S+1)` bits, saturating.
  - Ring counter is `$clog2(RING_S+1)` bits, cleared on RING entry.

## Timing
- Reset values:
  - `mode` = 0, state RUN.
  - `sw_mode0`..`sw_mode3` = 0.
  - `ringing` = 0.
  - Both counters 0; override latch clear.
  - `data_char` = `data_mode0`.
- Switch routing latency: `sw_pulse` at cycle t → `sw_modeN` at t+1, exactly one cycle wide.
- Owner change: `mode` updates on the clock edge that samples the frame boundary; `data_char` follows in the same cycle.
- `alarm_hit` at cycle t → `ringing` = 1 at t+1.
- `ringing` falls one cycle after the acknowledging `sw_pulse`, or one cycle after the `en_1hz` that brings the ring counter to `RING_S`.
- Simultaneous events:
  - `alarm_hit` with `sw_pulse`: alarm wins; the pulse is neither routed nor treated as an acknowledge.
  - `alarm_hit` while ringing: ring counter restarts at 0.
  - DIP change in the same cycle as timeout expiry: the DIP change wins; the latch is not set.
  - Frame boundary in the same cycle as a target change: the new target is applied.
- Reset asserted mid-frame: immediate return to reset values; the next frame starts under mode 0.

## Test plan
- `dip_sw` 0→4'b0010 at `index_char` = 10 → `mode` stays 0 until `char_done` with index 31, then `mode` = 2; `sw_pulse` = 4'b0001 before the boundary produces no `sw_mode*` pulse, and after the boundary yields `sw_mode2` = 4'b0001 one cycle later.
- Mode 1 with no switches for 30 `en_1hz` pulses → override set, `mode` = 0 after the next boundary; change `dip_sw` to 4'b0100 → `mode` = 3 after the following boundary.
- Mode 3 running, `alarm_hit` → `ringing` = 1 next cycle, `mode` = 0 at the boundary; `sw_pulse` = 4'b1000 → `ringing` = 0, no `sw_mode*` output, `mode` returns to 3 after the next boundary.
- Ringing with no acknowledge for 60 `en_1hz` pulses → `ringing` = 0 after the 60th; a second `alarm_hit` at 59 s → ring lasts 60 s from the re-hit.
- `alarm_hit` and `sw_pulse` = 4'b0001 in the same cycle in mode 2 → `ringing` = 1, `sw_mode2` stays 0.
- `rst` pulsed with `mode` = 2 mid-frame → `mode` = 0, `ringing` = 0, and `data_char` equals `data_mode0` while `rst` is high.

Source files
------------

// File: rtl/display_mode_arbiter.sv
// display_mode_arbiter: owns the LCD character path and switch pulses for the four mode blocks,
// switching owner only on frame boundaries, with inactivity timeout and alarm ring preemption.
module display_mode_arbiter #(
  parameter int TIMEOUT_S = 30,
  parameter int RING_S    = 60,
  parameter int LAST_IDX  = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_1hz,
  input  logic [3:0] dip_sw,
  input  logic [3:0] sw_pulse,
  input  logic       alarm_hit,
  input  logic [4:0] index_char,
  input  logic       char_done,
  input  logic [7:0] data_mode0,
  input  logic [7:0] data_mode1,
  input  logic [7:0] data_mode2,
  input  logic [7:0] data_mode3,
  output logic [7:0] data_char,
  output logic [3:0] sw_mode0,
  output logic [3:0] sw_mode1,
  output logic [3:0] sw_mode2,
  output logic [3:0] sw_mode3,
  output logic [1:0] mode,
  output logic       ringing
);
  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam int RW = $clog2(RING_S + 1);
  typedef enum logic [1:0] {RUN, PEND, RING} state_t;
  state_t        state;
  logic [IW-1:0] inact;
  logic [RW-1:0] ring_cnt;
  logic          ovr;
  logic [3:0]    dip_q, dip_ovr;
  logic [1:0]    dip_mode, free_target, target, next_mode;
  logic          boundary, any_sw, route, stop, dip_chg, expire, set_mode;
  assign dip_mode    = dip_sw == 4'b0001 ? 2'd1 : dip_sw == 4'b0010 ? 2'd2 : dip_sw == 4'b0100 ? 2'd3 : 2'd0;
  assign free_target = ovr ? 2'd0 : dip_mode;
  assign target      = state == RING ? 2'd0 : free_target;
  assign boundary    = char_done && index_char == 5'(LAST_IDX);
  assign next_mode   = boundary ? target : mode;
  assign any_sw      = |sw_pulse;
  assign route       = state == RUN && !alarm_hit;
  assign stop        = state == RING && !alarm_hit && (any_sw || (en_1hz && ring_cnt == RW'(RING_S - 1)));
  assign dip_chg     = dip_sw != dip_q;
  assign set_mode    = mode == 2'd1 || mode == 2'd2;
  // A DIP change on the expiry cycle means the user is active, so the latch stays clear
  assign expire      = state == RUN && set_mode && en_1hz && !any_sw && !dip_chg && !ovr
                       && inact == IW'(TIMEOUT_S - 1);
  assign data_char   = mode == 2'd0 ? data_mode0 : mode == 2'd1 ? data_mode1 : mode == 2'd2 ? data_mode2 : data_mode3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      mode     <= 2'd0;
      ringing  <= 1'b0;
      sw_mode0 <= '0;
      sw_mode1 <= '0;
      sw_mode2 <= '0;
      sw_mode3 <= '0;
      inact    <= '0;
      ring_cnt <= '0;
      ovr      <= 1'b0;
      dip_q    <= '0;
      dip_ovr  <= '0;
    end else begin
      mode     <= next_mode;
      dip_q    <= dip_sw;
      sw_mode0 <= route && mode == 2'd0 ? sw_pulse : 4'd0;
      sw_mode1 <= route && mode == 2'd1 ? sw_pulse : 4'd0;
      sw_mode2 <= route && mode == 2'd2 ? sw_pulse : 4'd0;
      sw_mode3 <= route && mode == 2'd3 ? sw_pulse : 4'd0;
      if (ovr && dip_sw != dip_ovr) ovr <= 1'b0;
      else if (expire) begin
        ovr     <= 1'b1;
        dip_ovr <= dip_sw;
      end
      if (next_mode != mode) inact <= '0;
      else if (state == RUN && set_mode)
        inact <= any_sw ? '0 : (en_1hz && inact != IW'(TIMEOUT_S)) ? inact + 1'b1 : inact;
      if (alarm_hit) begin
        state    <= RING;
        ringing  <= 1'b1;
        ring_cnt <= '0;
      end else if (state == RING) begin
        ringing  <= !stop;
        ring_cnt <= ring_cnt + RW'(en_1hz);
        if (stop) state <= next_mode == free_target ? RUN : PEND;
      end else state <= next_mode == target ? RUN : PEND;
    end
  end
endmodule

// File: tb/tb_display_mode_arbiter.sv
// tb_display_mode_arbiter: table-driven vectors plus directed sequences for timeout, ring and reset.
module tb_display_mode_arbiter;
  logic       clk = 0, rst = 1, en_1hz = 0, alarm_hit = 0, char_done = 0;
  logic [3:0] dip_sw = 0, sw_pulse = 0;
  logic [4:0] index_char = 0;
  logic [7:0] data_mode0 = 8'hA0, data_mode1 = 8'hA1, data_mode2 = 8'hA2, data_mode3 = 8'hA3;
  logic [7:0] data_char;
  logic [3:0] sw_mode0, sw_mode1, sw_mode2, sw_mode3;
  logic [1:0] mode;
  logic       ringing;
  int tests = 0, fails = 0;
  typedef struct {
    logic [3:0]  dip, sw;
    logic        alarm, done;
    logic [4:0]  idx;
    logic [1:0]  emode;
    logic        ering;
    logic [15:0] esw;
  } vec_t;
  vec_t v[17];
  display_mode_arbiter dut (
    .clk(clk), .rst(rst), .en_1hz(en_1hz), .dip_sw(dip_sw), .sw_pulse(sw_pulse),
    .alarm_hit(alarm_hit), .index_char(index_char), .char_done(char_done),
    .data_mode0(data_mode0), .data_mode1(data_mode1), .data_mode2(data_mode2), .data_mode3(data_mode3),
    .data_char(data_char), .sw_mode0(sw_mode0), .sw_mode1(sw_mode1), .sw_mode2(sw_mode2),
    .sw_mode3(sw_mode3), .mode(mode), .ringing(ringing)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(string name, logic [1:0] emode, logic ering, logic [15:0] esw);
    chk({name, " mode"}, 16'(mode), 16'(emode));
    chk({name, " ringing"}, 16'(ringing), 16'(ering));
    chk({name, " sw"}, {sw_mode3, sw_mode2, sw_mode1, sw_mode0}, esw);
    chk({name, " data"}, 16'(data_char), 16'({6'b101000, emode}));
  endtask
  task automatic cyc(logic [3:0] d, logic [3:0] s, logic a, logic dn, logic [4:0] i, logic e);
    dip_sw = d; sw_pulse = s; alarm_hit = a; char_done = dn; index_char = i; en_1hz = e;
    @(posedge clk); #1;
    sw_pulse = 0; alarm_hit = 0; char_done = 0; en_1hz = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    dip_sw = 0; sw_pulse = 0; alarm_hit = 0; char_done = 0; en_1hz = 0; index_char = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask
  initial begin
    v[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 16'h0000};
    v[1]  = '{4'b0000, 4'b0001, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 16'h0001};
    v[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 16'h0000};
    v[3]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 5'd10, 2'd0, 1'b0, 16'h0000};
    v[4]  = '{4'b0010, 4'b0001, 1'b0, 1'b0, 5'd11, 2'd0, 1'b0, 16'h0000};
    v[5]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 5'd31, 2'd2, 1'b0, 16'h0000};
    v[6]  = '{4'b0010, 4'b0001, 1'b0, 1'b0, 5'd0,  2'd2, 1'b0, 16'h0100};
    v[7]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 5'd0,  2'd2, 1'b0, 16'h0000};
    v[8]  = '{4'b0010, 4'b0001, 1'b1, 1'b0, 5'd3,  2'd2, 1'b1, 16'h0000};
    v[9]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 5'd31, 2'd0, 1'b1, 16'h0000};
    v[10] = '{4'b0010, 4'b1000, 1'b0, 1'b0, 5'd2,  2'd0, 1'b0, 16'h0000};
    v[11] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 5'd31, 2'd2, 1'b0, 16'h0000};
    v[12] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 5'd5,  2'd2, 1'b0, 16'h0000};
    v[13] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 5'd31, 2'd3, 1'b0, 16'h0000};
    v[14] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 5'd1,  2'd3, 1'b1, 16'h0000};
    v[15] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 5'd2,  2'd3, 1'b0, 16'h0000};
    v[16] = '{4'b0100, 4'b0010, 1'b0, 1'b0, 5'd3,  2'd3, 1'b0, 16'h2000};
    do_reset();
    chk_all("reset", 2'd0, 1'b0, 16'h0);
    foreach (v[k]) begin
      cyc(v[k].dip, v[k].sw, v[k].alarm, v[k].done, v[k].idx, 1'b0);
      chk_all($sformatf("vec%0d", k), v[k].emode, v[k].ering, v[k].esw);
    end
    // inactivity timeout in mode 1, then DIP change releases the override
    do_reset();
    cyc(4'b0001, 0, 0, 1, 5'd31, 0);
    chk_all("to_enter", 2'd1, 1'b0, 16'h0);
    repeat (10) cyc(4'b0001, 0, 0, 0, 5'd0, 1);
    cyc(4'b0001, 4'b0001, 0, 0, 5'd0, 0);
    chk_all("to_route", 2'd1, 1'b0, 16'h0010);
    repeat (29) cyc(4'b0001, 0, 0, 0, 5'd0, 1);
    cyc(4'b0001, 0, 0, 1, 5'd31, 0);
    chk_all("to_29s", 2'd1, 1'b0, 16'h0);
    cyc(4'b0001, 0, 0, 0, 5'd0, 1);
    cyc(4'b0001, 0, 0, 1, 5'd31, 0);
    chk_all("to_expired", 2'd0, 1'b0, 16'h0);
    cyc(4'b0100, 0, 0, 0, 5'd0, 0);
    chk_all("to_dip", 2'd0, 1'b0, 16'h0);
    cyc(4'b0100, 0, 0, 1, 5'd31, 0);
    chk_all("to_release", 2'd3, 1'b0, 16'h0);
    // DIP change on the expiry cycle wins over the timeout
    do_reset();
    cyc(4'b0001, 0, 0, 1, 5'd31, 0);
    repeat (29) cyc(4'b0001, 0, 0, 0, 5'd0, 1);
    cyc(4'b0010, 0, 0, 0, 5'd0, 1);
    cyc(4'b0010, 0, 0, 1, 5'd31, 0);
    chk_all("to_dipwins", 2'd2, 1'b0, 16'h0);
    // ring times out after 60 s, re-hit restarts the count
    do_reset();
    cyc(4'b0000, 0, 1, 0, 5'd0, 0);
    chk_all("ring_on", 2'd0, 1'b1, 16'h0);
    repeat (59) cyc(4'b0000, 0, 0, 0, 5'd0, 1);
    chk_all("ring_59", 2'd0, 1'b1, 16'h0);
    cyc(4'b0000, 0, 1, 0, 5'd0, 1);
    chk_all("ring_rehit", 2'd0, 1'b1, 16'h0);
    repeat (59) cyc(4'b0000, 0, 0, 0, 5'd0, 1);
    chk_all("ring_re59", 2'd0, 1'b1, 16'h0);
    cyc(4'b0000, 0, 0, 0, 5'd0, 1);
    chk_all("ring_re60", 2'd0, 1'b0, 16'h0);
    // reset mid-frame while in mode 2 and ringing
    cyc(4'b0010, 0, 0, 1, 5'd31, 0);
    cyc(4'b0010, 0, 1, 0, 5'd0, 0);
    cyc(4'b0010, 0, 0, 1, 5'd10, 0);
    chk_all("pre_rst", 2'd2, 1'b1, 16'h0);
    rst = 1;
    #1;
    chk_all("in_rst", 2'd0, 1'b0, 16'h0);
    @(posedge clk); #1;
    chk_all("in_rst2", 2'd0, 1'b0, 16'h0);
    rst = 0;
    cyc(4'b0010, 0, 0, 1, 5'd20, 0);
    chk_all("post_rst", 2'd0, 1'b0, 16'h0);
    cyc(4'b0010, 0, 0, 1, 5'd31, 0);
    chk_all("post_rst_frame", 2'd2, 1'b0, 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
